// File: rtl/scale_vector_pkg.sv
// Shared types and the per-element scale arithmetic for scale_vector_seq.
// SCALE_VECTOR_SAT_EN selects saturation of the scaled result; otherwise it wraps.
package scale_vector_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef logic [2:0] quarters_t;

  localparam int ROUND_OFS = 2;
  localparam int SHIFT     = 2;
  localparam int MAX_BITS  = 32;
  localparam int WIDE      = MAX_BITS + 8;

  // Computes round((a*q)/4) at a fixed wide width, then reduces the result
  // to `bits` bits; the caller truncates the sign-extended return value.
  function automatic logic signed [MAX_BITS-1:0] scale_elem(
    input logic signed [MAX_BITS-1:0] a,
    input quarters_t                  q,
    input int unsigned                bits
  );
    logic signed [WIDE-1:0] p;
    logic signed [WIDE-1:0] r;
    logic signed [WIDE-1:0] res;
`ifdef SCALE_VECTOR_SAT_EN
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
`endif
    p = WIDE'(a) * $signed(WIDE'({1'b0, q}));
    r = (p + WIDE'(ROUND_OFS)) >>> SHIFT;
`ifdef SCALE_VECTOR_SAT_EN
    hi  = (WIDE'(1) <<< (bits - 1)) - WIDE'(1);
    lo  = -(WIDE'(1) <<< (bits - 1));
    res = (r > hi) ? hi : ((r < lo) ? lo : r);
`else
    res = (r <<< (WIDE - bits)) >>> (WIDE - bits);
`endif
    return MAX_BITS'(res);
  endfunction

endpackage

// File: rtl/scale_lane.sv
// Combinational single-element scaler: r = a * q / 4, rounded half up.
module scale_lane
  import scale_vector_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic signed [BITS-1:0] a,
  input  quarters_t              q,
  output logic signed [BITS-1:0] r
);

  assign r = BITS'(scale_elem(MAX_BITS'(a), q, BITS));

endmodule

// File: rtl/scale_vector_seq.sv
// Time-multiplexed vector scaler: LANES elements per beat over N/LANES beats,
// valid/ready handshake on both sides. Result mode set by SCALE_VECTOR_SAT_EN.
module scale_vector_seq
  import scale_vector_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int N     = 10,
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [BITS-1:0] a [N],
  input  quarters_t              quarters,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [BITS-1:0] c [N]
);

  localparam int B  = N / LANES;
  localparam int CW = (B > 1) ? $clog2(B) : 1;

  if (N % LANES != 0) begin : g_lanes_check
    $error("scale_vector_seq: N must be a multiple of LANES");
  end
  if (BITS > MAX_BITS) begin : g_bits_check
    $error("scale_vector_seq: BITS exceeds MAX_BITS");
  end

  state_e                 state;
  logic [CW-1:0]          beat;
  quarters_t              q_reg;
  logic signed [BITS-1:0] a_buf  [B][LANES];
  logic signed [BITS-1:0] lane_r [LANES];
  logic                   accept;

  // DONE hands ready straight through so a waiting source is taken on release.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
      q_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= RUN;
            beat  <= '0;
            q_reg <= quarters;
          end
        end
        RUN: begin
          if (beat == CW'(B - 1)) state <= DONE;
          else                    beat  <= beat + 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              state <= RUN;
              beat  <= '0;
              q_reg <= quarters;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    scale_lane #(.BITS(BITS)) u_lane (
      .a (a_buf[beat][l]),
      .q (q_reg),
      .r (lane_r[l])
    );
  end

  // Buffer is stored beat-major so the lane mux indexes by beat directly.
  for (genvar i = 0; i < N; i++) begin : g_elem
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_buf[i / LANES][i % LANES] <= '0;
        c[i]                        <= '0;
      end else begin
        if (accept)
          a_buf[i / LANES][i % LANES] <= a[i];
        if ((state == RUN) && (beat == CW'(i / LANES)))
          c[i] <= lane_r[i % LANES];
      end
    end
  end

endmodule

// File: tb/tb_scale_vector_seq.sv
// Directed testbench for scale_vector_seq (N=10, LANES=2, BITS=16).
module tb_scale_vector_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] a [10];
  logic [2:0]         quarters;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] c [10];
  logic signed [15:0] expv [10];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scale_vector_seq #(.BITS(16), .N(10), .LANES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .quarters  (quarters),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents the current a/quarters and returns one sample after the accepting edge.
  task automatic accept_vec(input logic [2:0] q);
    int n = 0;
    quarters = q;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    quarters  = 3'd5;
    for (int i = 0; i < 10; i++) a[i] = 16'sd123;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (c[i] !== 16'sd0) begin errors++; $display("FAIL reset_c[%0d]: got %0d required 0", i, c[i]); end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_basic();
    a    = '{16'sd100, -16'sd100, 16'sd7, -16'sd7, 16'sd40, -16'sd40, 16'sd1, 16'sd2, 16'sd3, -16'sd1};
    expv = '{16'sd75, -16'sd75, 16'sd5, -16'sd5, 16'sd30, -16'sd30, 16'sd1, 16'sd2, 16'sd2, -16'sd1};
    accept_vec(3'd3);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_run_in_ready: got %b required 0", in_ready); end
    for (int t = 1; t <= 5; t++) begin
      tick();
      checks++;
      if (out_valid !== (t == 5)) begin
        errors++;
        $display("FAIL basic_latency cycle %0d: out_valid=%b required %b", t, out_valid, (t == 5));
      end
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (c[i] !== expv[i]) begin errors++; $display("FAIL basic_c[%0d]: got %0d required %0d", i, c[i], expv[i]); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_drain: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_gains();
    logic signed [15:0] saved [10];
    a = '{16'sd100, -16'sd100, 16'sd7, -16'sd7, 16'sd40, -16'sd40, 16'sd1, 16'sd2, 16'sd3, -16'sd1};
    accept_vec(3'd0);
    for (int t = 0; t < 5; t++) tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (c[i] !== 16'sd0) begin errors++; $display("FAIL gain0_c[%0d]: got %0d required 0", i, c[i]); end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    for (int i = 0; i < 10; i++) begin
      a[i]     = 16'($urandom);
      saved[i] = a[i];
    end
    accept_vec(3'd4);
    for (int t = 0; t < 5; t++) tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL gain4_valid: got %b required 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (c[i] !== saved[i]) begin errors++; $display("FAIL gain4_c[%0d]: got %0d required %0d", i, c[i], saved[i]); end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) begin
      a[i]    = 16'sd0;
      expv[i] = 16'sd0;
    end
    a[0] = 16'sd32767;
    a[1] = -16'sd32768;
`ifdef SCALE_VECTOR_SAT_EN
    expv[0] = 16'sd32767;
    expv[1] = -16'sd32768;
`else
    expv[0] = -16'sd8194;
    expv[1] = 16'sd8192;
`endif
    accept_vec(3'd7);
    for (int t = 0; t < 5; t++) tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (c[i] !== expv[i]) begin errors++; $display("FAIL overflow_c[%0d]: got %0d required %0d", i, c[i], expv[i]); end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    a    = '{16'sd100, -16'sd100, 16'sd7, -16'sd7, 16'sd40, -16'sd40, 16'sd1, 16'sd2, 16'sd3, -16'sd1};
    expv = '{16'sd75, -16'sd75, 16'sd5, -16'sd5, 16'sd30, -16'sd30, 16'sd1, 16'sd2, 16'sd2, -16'sd1};
    accept_vec(3'd3);
    for (int t = 0; t < 5; t++) tick();
    a        = '{16'sd8, -16'sd8, 16'sd12, -16'sd12, 16'sd1, -16'sd1, 16'sd2, -16'sd2, 16'sd0, 16'sd1000};
    quarters = 3'd2;
    in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b required 1/0", t, out_valid, in_ready);
      end
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (c[i] !== expv[i]) begin errors++; $display("FAIL bp_hold_c[%0d]: got %0d required %0d", i, c[i], expv[i]); end
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b required 1", in_ready); end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_reaccept: out_valid=%b in_ready=%b required 0/0", out_valid, in_ready);
    end
    expv = '{16'sd4, -16'sd4, 16'sd6, -16'sd6, 16'sd1, 16'sd0, 16'sd1, -16'sd1, 16'sd0, 16'sd500};
    for (int t = 1; t <= 5; t++) begin
      tick();
      checks++;
      if (out_valid !== (t == 5)) begin
        errors++;
        $display("FAIL bp_latency cycle %0d: out_valid=%b required %b", t, out_valid, (t == 5));
      end
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (c[i] !== expv[i]) begin errors++; $display("FAIL bp_next_c[%0d]: got %0d required %0d", i, c[i], expv[i]); end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 0; i < 10; i++) a[i] = 16'(4 * (i + 1));
    out_ready = 1'b1;
    quarters  = 3'd0;
    in_valid  = 1'b1;
    tick();
    for (int v = 0; v < 8; v++) begin
      quarters = 3'(v + 1);
      for (int t = 1; t <= 5; t++) begin
        tick();
        checks++;
        if (out_valid !== (t == 5)) begin
          errors++;
          $display("FAIL b2b_valid vec %0d cycle %0d: out_valid=%b required %b", v, t, out_valid, (t == 5));
        end
        if (out_valid === 1'b1) pulses++;
      end
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (c[i] !== 16'(v * (i + 1))) begin
          errors++;
          $display("FAIL b2b_c vec %0d [%0d]: got %0d required %0d", v, i, c[i], v * (i + 1));
        end
      end
      if (v == 7) in_valid = 1'b0;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (pulses != 8) begin errors++; $display("FAIL b2b_count: got %0d vectors required 8", pulses); end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    a = '{16'sd100, -16'sd100, 16'sd7, -16'sd7, 16'sd40, -16'sd40, 16'sd1, 16'sd2, 16'sd3, -16'sd1};
    accept_vec(3'd3);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (c[i] !== 16'sd0) begin errors++; $display("FAIL rst_mid_c[%0d]: got %0d required 0", i, c[i]); end
    end
    tick();
    rst_n = 1'b1;
    tick();
    a    = '{16'sd11, -16'sd22, 16'sd33, -16'sd44, 16'sd55, -16'sd66, 16'sd77, -16'sd88, 16'sd99, -16'sd111};
    expv = a;
    accept_vec(3'd4);
    for (int t = 1; t <= 5; t++) begin
      tick();
      checks++;
      if (out_valid !== (t == 5)) begin
        errors++;
        $display("FAIL rst_next_latency cycle %0d: out_valid=%b required %b", t, out_valid, (t == 5));
      end
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (c[i] !== expv[i]) begin errors++; $display("FAIL rst_next_c[%0d]: got %0d required %0d", i, c[i], expv[i]); end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gains();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
